// File: rtl/open_list_sched_pkg.sv
// Shared definitions for the A* open-list scheduler.
// Holds the FSM state encoding, the default core dimensions and the
// default-width entry record used by the surrounding A* core.
package open_list_sched_pkg;

  localparam int DEF_DEPTH  = 8;
  localparam int DEF_COST_W = 12;
  localparam int DEF_ID_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_INSERT = 2'd1,
    ST_POP    = 2'd2
  } state_t;

  // Open-list entry at the core's default widths.
  typedef struct packed {
    logic [DEF_COST_W-1:0] cost;
    logic [DEF_ID_W-1:0]   id;
  } entry_t;

endpackage

// File: rtl/open_list_mem.sv
// Sorted slot array for the open list with insert-shift and pop-shift paths.
// Latency: all writes land on the next rising edge; reads are combinational.
// Backpressure: none here; the controller only drives one operation per cycle.
// Ports: i_move copies slot[i_pos-1] into slot[i_pos]; i_write stores the new
//        entry into slot[i_pos]; i_pop shifts every slot down by one.
//        o_prev_cost is slot[i_pos-1].cost, o_head_* is slot 0.
module open_list_mem
  import open_list_sched_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int COST_W = DEF_COST_W,
  parameter int ID_W   = DEF_ID_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_move,
  input  logic              i_write,
  input  logic              i_pop,
  input  logic [AW-1:0]     i_pos,
  input  logic [COST_W-1:0] i_new_cost,
  input  logic [ID_W-1:0]   i_new_id,
  output logic [COST_W-1:0] o_prev_cost,
  output logic [COST_W-1:0] o_head_cost,
  output logic [ID_W-1:0]   o_head_id
);

  typedef struct packed {
    logic [COST_W-1:0] cost;
    logic [ID_W-1:0]   id;
  } slot_t;

  slot_t         r_slot [DEPTH];
  logic [AW-1:0] w_prev_pos;

  // Wraps when i_pos is 0; the controller ignores o_prev_cost in that case.
  assign w_prev_pos  = i_pos - AW'(1);
  assign o_prev_cost = r_slot[w_prev_pos].cost;
  assign o_head_cost = r_slot[0].cost;
  assign o_head_id   = r_slot[0].id;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_slot[k] <= '0;
      end
    end else if (i_pop) begin
      // The top slot keeps its stale value; it is beyond count afterwards.
      for (int k = 0; k < DEPTH - 1; k++) begin
        r_slot[k] <= r_slot[k+1];
      end
    end else if (i_move) begin
      r_slot[i_pos] <= r_slot[w_prev_pos];
    end else if (i_write) begin
      r_slot[i_pos] <= '{cost: i_new_cost, id: i_new_id};
    end
  end

endmodule

// File: rtl/open_list_sched.sv
// A* open list: sorted insert (stable among equal costs) and pop-minimum.
// Latency: insert = (entries costlier than new)+1 cycles busy; pop result 2 cycles after accept.
// Backpressure: ins_ready/pop_ready low when busy, full/empty or clearing; pop beats insert.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_clear synchronous flush;
//        i_ins_valid/i_ins_cost/i_ins_id/o_ins_ready insert handshake;
//        i_pop_valid/o_pop_ready pop handshake; o_out_valid/o_out_cost/o_out_id popped entry;
//        o_count/o_full/o_empty/o_busy status.
module open_list_sched
  import open_list_sched_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int COST_W = DEF_COST_W,
  parameter int ID_W   = DEF_ID_W
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_clear,
  input  logic                   i_ins_valid,
  input  logic [COST_W-1:0]      i_ins_cost,
  input  logic [ID_W-1:0]        i_ins_id,
  output logic                   o_ins_ready,
  input  logic                   i_pop_valid,
  output logic                   o_pop_ready,
  output logic                   o_out_valid,
  output logic [COST_W-1:0]      o_out_cost,
  output logic [ID_W-1:0]        o_out_id,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty,
  output logic                   o_busy
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  state_t            r_state;
  logic [CNT_W-1:0]  r_count;
  // Write position = scan index + 1; zero means the scan has passed slot 0.
  logic [AW-1:0]     r_pos;
  logic [COST_W-1:0] r_new_cost;
  logic [ID_W-1:0]   r_new_id;
  logic              r_out_valid;
  logic [COST_W-1:0] r_out_cost;
  logic [ID_W-1:0]   r_out_id;

  logic              w_idle;
  logic              w_pop_acc;
  logic              w_ins_acc;
  logic              w_in_insert;
  logic              w_shift;
  logic              w_mem_write;
  logic              w_mem_pop;
  logic [COST_W-1:0] w_prev_cost;
  logic [COST_W-1:0] w_head_cost;
  logic [ID_W-1:0]   w_head_id;

  assign w_idle      = (r_state == ST_IDLE);
  assign o_full      = (r_count == FULL_CNT);
  assign o_empty     = (r_count == '0);
  assign o_busy      = !w_idle;
  assign o_count     = r_count;
  assign o_out_valid = r_out_valid;
  assign o_out_cost  = r_out_cost;
  assign o_out_id    = r_out_id;

  assign o_pop_ready = w_idle & !o_empty & !i_clear;
  assign o_ins_ready = w_idle & !o_full & !i_clear & !(i_pop_valid & !o_empty);
  assign w_pop_acc   = i_pop_valid & o_pop_ready;
  assign w_ins_acc   = i_ins_valid & o_ins_ready;

  // Strict '>' keeps equal-cost entries in front of the newcomer (FIFO among ties).
  assign w_in_insert = (r_state == ST_INSERT) & !i_clear;
  assign w_shift     = w_in_insert & (r_pos != '0) & (w_prev_cost > r_new_cost);
  assign w_mem_write = w_in_insert & !w_shift;
  assign w_mem_pop   = (r_state == ST_POP) & !i_clear;

  open_list_mem #(
    .DEPTH  (DEPTH),
    .COST_W (COST_W),
    .ID_W   (ID_W)
  ) u_mem (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_move      (w_shift),
    .i_write     (w_mem_write),
    .i_pop       (w_mem_pop),
    .i_pos       (r_pos),
    .i_new_cost  (r_new_cost),
    .i_new_id    (r_new_id),
    .o_prev_cost (w_prev_cost),
    .o_head_cost (w_head_cost),
    .o_head_id   (w_head_id)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_pos       <= '0;
      r_new_cost  <= '0;
      r_new_id    <= '0;
      r_out_valid <= 1'b0;
      r_out_cost  <= '0;
      r_out_id    <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (i_clear) begin
        r_state <= ST_IDLE;
        r_count <= '0;
        r_pos   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_pop_acc) begin
              r_state <= ST_POP;
            end else if (w_ins_acc) begin
              r_new_cost <= i_ins_cost;
              r_new_id   <= i_ins_id;
              // count < DEPTH here, so it fits the position width.
              r_pos      <= r_count[AW-1:0];
              r_state    <= ST_INSERT;
            end
          end
          ST_INSERT: begin
            if (w_shift) begin
              r_pos <= r_pos - AW'(1);
            end else begin
              r_count <= r_count + CNT_W'(1);
              r_state <= ST_IDLE;
            end
          end
          ST_POP: begin
            r_out_valid <= 1'b1;
            r_out_cost  <= w_head_cost;
            r_out_id    <= w_head_id;
            r_count     <= r_count - CNT_W'(1);
            r_state     <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_open_list_sched.sv
module tb_open_list_sched;

  localparam int DEPTH  = 8;
  localparam int COST_W = 12;
  localparam int ID_W   = 8;

  logic              i_clk;
  logic              i_rst_n;
  logic              i_clear;
  logic              i_ins_valid;
  logic [COST_W-1:0] i_ins_cost;
  logic [ID_W-1:0]   i_ins_id;
  logic              o_ins_ready;
  logic              i_pop_valid;
  logic              o_pop_ready;
  logic              o_out_valid;
  logic [COST_W-1:0] o_out_cost;
  logic [ID_W-1:0]   o_out_id;
  logic [3:0]        o_count;
  logic              o_full;
  logic              o_empty;
  logic              o_busy;

  int total = 0;
  int bad   = 0;

  open_list_sched #(
    .DEPTH  (DEPTH),
    .COST_W (COST_W),
    .ID_W   (ID_W)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (i_clear),
    .i_ins_valid (i_ins_valid),
    .i_ins_cost  (i_ins_cost),
    .i_ins_id    (i_ins_id),
    .o_ins_ready (o_ins_ready),
    .i_pop_valid (i_pop_valid),
    .o_pop_ready (o_pop_ready),
    .o_out_valid (o_out_valid),
    .o_out_cost  (o_out_cost),
    .o_out_id    (o_out_id),
    .o_count     (o_count),
    .o_full      (o_full),
    .o_empty     (o_empty),
    .o_busy      (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_ins_ready(input string tag);
    int n;
    n = 0;
    while (!o_ins_ready && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_ins_ready"}, o_ins_ready, 1);
  endtask

  // Counts cycles spent in INSERT after the accept edge and watches ins_ready.
  task automatic wait_insert_done(input int exp_lat, input string tag);
    int   lat;
    logic rdy_seen;
    lat = 0;
    rdy_seen = 1'b0;
    while (o_busy && lat < 40) begin
      lat++;
      if (o_ins_ready) rdy_seen = 1'b1;
      tick();
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_rdy_low"}, rdy_seen, 0);
  endtask

  task automatic do_insert(input int cost, input int id, input int exp_lat, input string tag);
    wait_ins_ready(tag);
    i_ins_valid = 1'b1;
    i_ins_cost  = COST_W'(cost);
    i_ins_id    = ID_W'(id);
    tick();
    i_ins_valid = 1'b0;
    wait_insert_done(exp_lat, tag);
  endtask

  task automatic do_pop(input int exp_cost, input int exp_id, input string tag);
    int n;
    n = 0;
    while (!o_pop_ready && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_pop_ready"}, o_pop_ready, 1);
    i_pop_valid = 1'b1;
    tick();
    i_pop_valid = 1'b0;
    chk({tag, "_vld_early"}, o_out_valid, 0);
    tick();
    chk({tag, "_vld"}, o_out_valid, 1);
    chk({tag, "_id"}, o_out_id, exp_id);
    chk({tag, "_cost"}, o_out_cost, exp_cost);
    tick();
    chk({tag, "_vld_pulse"}, o_out_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n     = 1'b0;
    i_clear     = 1'b0;
    i_ins_valid = 1'b0;
    i_ins_cost  = '0;
    i_ins_id    = '0;
    i_pop_valid = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_count", o_count, 0);
    chk("rst_empty", o_empty, 1);
    chk("rst_full", o_full, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_out_cost", o_out_cost, 0);
    chk("rst_out_id", o_out_id, 0);
    chk("rst_ins_ready", o_ins_ready, 1);
    chk("rst_pop_ready", o_pop_ready, 0);
    i_rst_n = 1'b1;
    tick();

    // Basic sort: 30/1, 10/2, 20/3 -> pops 2,3,1
    do_insert(30, 1, 1, "b30");
    do_insert(10, 2, 2, "b10");
    do_insert(20, 3, 2, "b20");
    chk("b_count", o_count, 3);
    do_pop(10, 2, "bp0");
    do_pop(20, 3, "bp1");
    do_pop(30, 1, "bp2");
    chk("b_empty", o_empty, 1);

    // Insert latency: 5 into {10,20,30} takes 4 cycles, 40 takes 1
    do_insert(10, 11, 1, "l10");
    do_insert(20, 12, 1, "l20");
    do_insert(30, 13, 1, "l30");
    do_insert(5, 14, 4, "l5");
    do_insert(40, 15, 1, "l40");
    chk("l_count", o_count, 5);
    do_pop(5, 14, "lp0");
    do_pop(10, 11, "lp1");
    do_pop(20, 12, "lp2");
    do_pop(30, 13, "lp3");
    do_pop(40, 15, "lp4");

    // Tie stability
    do_insert(7, 4, 1, "t4");
    do_insert(7, 5, 1, "t5");
    do_insert(7, 6, 1, "t6");
    do_pop(7, 4, "tp0");
    do_pop(7, 5, "tp1");
    do_pop(7, 6, "tp2");

    // Fill with descending costs: every insert walks the whole list
    for (int k = 0; k < DEPTH; k++) begin
      do_insert((DEPTH - k) * 10, 20 + k, k + 1, "fill");
    end
    chk("full_flag", o_full, 1);
    chk("full_count", o_count, 8);
    i_ins_valid = 1'b1;
    i_ins_cost  = COST_W'(1);
    i_ins_id    = ID_W'(99);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("full_ins_ready", o_ins_ready, 0);
      chk("full_hold_count", o_count, 8);
      chk("full_busy", o_busy, 0);
    end
    i_ins_valid = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      do_pop((DEPTH - k) * 10, 20 + k, "drain");
    end
    chk("drain_empty", o_empty, 1);

    // Pop on empty is held off; outputs keep last popped entry
    i_pop_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("empty_pop_ready", o_pop_ready, 0);
      chk("empty_out_valid", o_out_valid, 0);
      chk("empty_busy", o_busy, 0);
      chk("hold_out_cost", o_out_cost, 80);
      chk("hold_out_id", o_out_id, 20);
    end
    i_pop_valid = 1'b0;

    // Simultaneous insert and pop with two entries: pop wins
    do_insert(50, 40, 1, "s50");
    do_insert(30, 41, 2, "s30");
    i_ins_valid = 1'b1;
    i_ins_cost  = COST_W'(40);
    i_ins_id    = ID_W'(42);
    i_pop_valid = 1'b1;
    #1;
    chk("sim_pop_ready", o_pop_ready, 1);
    chk("sim_ins_ready", o_ins_ready, 0);
    tick();
    i_pop_valid = 1'b0;
    #1;
    chk("sim_in_pop_busy", o_busy, 1);
    chk("sim_in_pop_ins_ready", o_ins_ready, 0);
    tick();
    chk("sim_out_valid", o_out_valid, 1);
    chk("sim_out_id", o_out_id, 41);
    chk("sim_idle_ins_ready", o_ins_ready, 1);
    tick();
    i_ins_valid = 1'b0;
    chk("sim_ins_busy", o_busy, 1);
    wait_insert_done(2, "sim_ins");
    chk("sim_count", o_count, 2);
    do_pop(40, 42, "sp0");
    do_pop(50, 40, "sp1");

    // Clear in the middle of an insert
    do_insert(10, 71, 1, "c10");
    do_insert(20, 72, 1, "c20");
    do_insert(30, 73, 1, "c30");
    wait_ins_ready("c5");
    i_ins_valid = 1'b1;
    i_ins_cost  = COST_W'(5);
    i_ins_id    = ID_W'(74);
    tick();
    i_ins_valid = 1'b0;
    chk("clr_busy_before", o_busy, 1);
    tick();
    i_clear = 1'b1;
    #1;
    chk("clr_ins_ready", o_ins_ready, 0);
    chk("clr_pop_ready", o_pop_ready, 0);
    tick();
    i_clear = 1'b0;
    #1;
    chk("clr_count", o_count, 0);
    chk("clr_empty", o_empty, 1);
    chk("clr_busy", o_busy, 0);
    chk("clr_out_valid", o_out_valid, 0);
    chk("clr_pop_ready_after", o_pop_ready, 0);

    // Async reset in the middle of a pop
    do_insert(15, 50, 1, "r15");
    do_insert(25, 51, 1, "r25");
    chk("r_pop_ready", o_pop_ready, 1);
    i_pop_valid = 1'b1;
    tick();
    i_pop_valid = 1'b0;
    chk("r_in_pop", o_busy, 1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("r_count", o_count, 0);
    chk("r_empty", o_empty, 1);
    chk("r_busy", o_busy, 0);
    chk("r_out_valid", o_out_valid, 0);
    chk("r_out_cost", o_out_cost, 0);
    #2;
    i_rst_n = 1'b1;
    tick();
    chk("r_no_late_valid", o_out_valid, 0);
    chk("r_count_after", o_count, 0);
    do_insert(9, 60, 1, "r9");
    do_pop(9, 60, "rp0");
    chk("final_empty", o_empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/open_list_sched.md
OPEN_LIST_SCHED -- requirements
Module: open_list_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of open-list entries (power of two, >=2).
REQ-002 SHALL have parameter COST_W, default 12, f-cost width.
REQ-003 SHALL have parameter ID_W, default 8, node-id width.
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 clear  input  1  synchronous flush of all entries.
REQ-007 ins_valid  input  1  insert request from the expander.
REQ-008 ins_cost  input  COST_W  f-cost of the node being inserted.
REQ-009 ins_id  input  ID_W  id of the node being inserted.
REQ-010 ins_ready  output  1  insert can be accepted this cycle.
REQ-011 pop_valid  input  1  request to remove the minimum-cost entry.
REQ-012 pop_ready  output  1  pop can be accepted this cycle.
REQ-013 out_valid  output  1  one-cycle pulse: out_cost/out_id carry the popped entry.
REQ-014 out_cost  output  COST_W  popped f-cost.
REQ-015 out_id  output  ID_W  popped node id.
REQ-016 count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-017 full, empty, busy  output  1 each  count==DEPTH, count==0, FSM not in IDLE.

Function
REQ-018 Storage SHALL hold entries {cost,id} in slots 0..count-1, ascending by cost; slot 0 is the minimum.
REQ-019 FSM states SHALL be IDLE, INSERT, POP; requests are accepted only in IDLE.
REQ-020 pop_ready SHALL equal IDLE & !empty & !clear.
REQ-021 ins_ready SHALL equal IDLE & !full & !clear & !(pop_valid & !empty); pop wins simultaneous requests.
REQ-022 Insert accept (ins_valid & ins_ready) SHALL latch cost/id, set scan index i=count-1, go to INSERT.
REQ-023 In INSERT, each cycle: if i>=0 and slot[i].cost > new cost, slot[i+1]<=slot[i], i<=i-1; else slot[i+1]<=new, count<=count+1, go IDLE.
REQ-024 Equal costs SHALL NOT be shifted: a new entry lands after existing equal-cost entries (stable, FIFO among ties).
REQ-025 Insert latency SHALL be (number of entries with cost > new cost)+1 cycles in INSERT; empty list = 1 cycle.
REQ-026 Pop accept SHALL go to POP; in POP, out_cost/out_id<=slot[0], out_valid pulses for exactly that next cycle, all slots shift down one in parallel, count<=count-1, go IDLE.
REQ-027 out_cost/out_id SHALL hold their last value while out_valid is low.
REQ-028 Full: ins_valid SHALL be held off (ins_ready=0), never dropped or overwriting.
REQ-029 Empty: pop_valid SHALL be held off (pop_ready=0); out_valid stays 0.
REQ-030 clear asserted in any state SHALL next cycle set count=0, state IDLE, out_valid=0; an in-progress insert is discarded; clear overrides any same-cycle accept.
REQ-031 Slot contents beyond count SHALL be don't-care and never presented on outputs.

Reset
REQ-032 Reset low SHALL immediately force: state IDLE, count=0, empty=1, full=0, busy=0, out_valid=0, out_cost=0, out_id=0, scan index 0.
REQ-033 Reset mid-INSERT or mid-POP SHALL abandon the operation; no partial entry survives.
REQ-034 Slot storage SHALL be reset to zero.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding, the entry record (cost,id) type, and default DEPTH/COST_W/ID_W constants used by the A* core.
REQ-036 Slot array plus shift/write-enable logic SHALL be one sub-module, open_list_mem; FSM, arbitration and count stay in open_list_sched.

Verification
REQ-037 Reset, then inserts costs 30,10,20 (ids 1,2,3) -> slots {10/2,20/3,30/1}, count=3; three pops -> out_id 2,3,1 each with one-cycle out_valid.
REQ-038 Insert 5 into {10,20,30} -> INSERT lasts 4 cycles, ins_ready low throughout; insert 40 -> INSERT lasts 1 cycle.
REQ-039 Insert cost 7 ids 4,5,6 in order then pop three times -> out_id 4,5,6 (tie stability).
REQ-040 Fill 8 entries -> full=1, ins_ready=0 with ins_valid held, count stays 8; pop on empty list -> pop_ready=0, no out_valid.
REQ-041 ins_valid and pop_valid both high with count=2 -> pop accepted, insert accepted on the cycle after return to IDLE.
REQ-042 clear asserted during INSERT, then separately Reset pulsed low mid-POP -> count=0, empty=1, out_valid=0, subsequent insert of 9 then pop returns 9.
